// File: rtl/csa_resolver.sv
// Two-stage carry-save to binary resolver: res = ps + (pc << 1).
// Each stage resolves one 4-bit carry-lookahead group behind a valid/ready handshake.
module csa_resolver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] ps,
   input  logic [7:0] pc,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [9:0] res,
   output logic [7:0] res_cnt
);

   // 4-bit lookahead group; returns {carry_out, sum}
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic       s1_valid;
   logic [4:0] s1_lo;
   logic       s1_c4;
   logic [2:0] s1_ps_hi;
   logic [3:0] s1_pc_hi;

   logic       s2_adv;
   logic       s1_adv;
   logic [4:0] lo_sum;
   logic [4:0] hi_sum;

   always_comb begin
      s2_adv   = !out_valid || out_ready;
      s1_adv   = !s1_valid || s2_adv;
      in_ready = s1_adv;
      lo_sum   = cla4(ps[4:1], pc[3:0], 1'b0);
      // ps[8] does not exist, so the upper group's a[3] is tied low
      hi_sum   = cla4({1'b0, s1_ps_hi}, s1_pc_hi, s1_c4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_lo     <= '0;
         s1_c4     <= 1'b0;
         s1_ps_hi  <= '0;
         s1_pc_hi  <= '0;
         out_valid <= 1'b0;
         res       <= '0;
         res_cnt   <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_lo    <= {lo_sum[3:0], ps[0]};
               s1_c4    <= lo_sum[4];
               s1_ps_hi <= ps[7:5];
               s1_pc_hi <= pc[7:4];
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               res <= {hi_sum, s1_lo};
            end
         end
         if (out_valid && out_ready) begin
            res_cnt <= res_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomized checks for csa_resolver: arithmetic, latency, backpressure,
// asynchronous reset, handshake counter wrap and ordering.
module tb_csa_resolver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] ps = 8'h00;
   logic [7:0] pc = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [9:0] res;
   logic [7:0] res_cnt;

   int checks = 0;
   int errors = 0;

   csa_resolver dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ps        (ps),
      .pc        (pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .res_cnt   (res_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (res !== 10'h000) begin
         errors++; $display("FAIL reset_res got %h want 000", res);
      end
      checks++;
      if (res_cnt !== 8'h00) begin
         errors++; $display("FAIL reset_res_cnt got %h want 00", res_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [9:0] exp);
      logic [7:0] cnt0;
      cnt0 = res_cnt;
      ps = a;
      pc = b;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready got %b want 1", name, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL %s early_out_valid got %b want 0", name, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || res !== exp) begin
         errors++;
         $display("FAIL %s result got v=%b res=%h want v=1 res=%h", name, out_valid, res, exp);
      end
      checks++;
      if (res_cnt !== cnt0) begin
         errors++; $display("FAIL %s cnt_before got %h want %h", name, res_cnt, cnt0);
      end
      tick();
      checks++;
      if (res_cnt !== cnt0 + 8'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s cnt_after got cnt=%h v=%b want cnt=%h v=0", name, res_cnt,
                  out_valid, cnt0 + 8'd1);
      end
   endtask

   task automatic test_back_to_back();
      logic       iv   [10];
      logic [7:0] tps  [10];
      logic [7:0] tpc  [10];
      logic       ordy [10];
      logic       eir  [10];
      logic       eov  [10];
      logic [9:0] eres [10];
      logic [7:0] cnt0;
      iv   = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
      tps  = '{8'h01, 8'h10, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00};
      tpc  = '{8'h01, 8'h20, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
      ordy = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
      eir  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
      eov  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
      eres = '{10'h0, 10'h0, 10'h003, 10'h003, 10'h003, 10'h003, 10'h050, 10'h180, 10'h081,
               10'h0};
      cnt0 = res_cnt;
      for (int i = 0; i < 10; i++) begin
         in_valid = iv[i];
         ps = tps[i];
         pc = tpc[i];
         out_ready = ordy[i];
         #1;
         checks++;
         if (in_ready !== eir[i] || out_valid !== eov[i]) begin
            errors++;
            $display("FAIL b2b_cycle%0d ctrl got rdy=%b v=%b want rdy=%b v=%b", i + 1,
                     in_ready, out_valid, eir[i], eov[i]);
         end
         if (eov[i]) begin
            checks++;
            if (res !== eres[i]) begin
               errors++;
               $display("FAIL b2b_cycle%0d res got %h want %h", i + 1, res, eres[i]);
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (res_cnt !== cnt0 + 8'd4) begin
         errors++; $display("FAIL b2b_count got %h want %h", res_cnt, cnt0 + 8'd4);
      end
   endtask

   task automatic test_reset_inflight();
      out_ready = 1'b0;
      in_valid = 1'b1;
      ps = 8'h12;
      pc = 8'h34;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_cnt === 8'h00) begin
         errors++;
         $display("FAIL inflight_full got v=%b rdy=%b cnt=%h want v=1 rdy=0 cnt!=0",
                  out_valid, in_ready, res_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== 10'h000 || res_cnt !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got v=%b res=%h cnt=%h want v=0 res=000 cnt=00",
                  out_valid, res, res_cnt);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL async_reset_in_ready got %b want 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      ps = 8'h0F;
      pc = 8'h08;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_ready got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stale_result got v=%b res=%h want v=0", out_valid, res);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || res !== 10'h01F) begin
         errors++;
         $display("FAIL post_reset_first got v=%b res=%h want v=1 res=01f", out_valid, res);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [7:0] cnt0;
      int sent;
      int hs;
      cnt0 = res_cnt;
      sent = 0;
      hs = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 400 && hs < 256; cyc++) begin
         in_valid = (sent < 256);
         ps = 8'(sent);
         pc = ~8'(sent);
         #1;
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) hs++;
         @(posedge clk);
         #1;
         if (hs == 100 && (out_valid && out_ready) == 1'b0 || hs == 100) begin
            if (cyc >= 0 && hs == 100 && sent < 256 && res_cnt !== cnt0 + 8'd100) begin
               checks++;
               errors++;
               $display("FAIL wrap_mid got %h want %h", res_cnt, cnt0 + 8'd100);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (hs != 256) begin
         errors++; $display("FAIL wrap_handshakes got %0d want 256", hs);
      end
      checks++;
      if (res_cnt !== cnt0) begin
         errors++; $display("FAIL wrap_count got %h want %h", res_cnt, cnt0);
      end
      tick();
   endtask

   task automatic test_count_mid();
      logic [7:0] cnt0;
      cnt0 = res_cnt;
      out_ready = 1'b1;
      in_valid = 1'b1;
      ps = 8'h01;
      pc = 8'h00;
      for (int i = 0; i < 12; i++) tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (res_cnt !== cnt0 + 8'd12) begin
         errors++; $display("FAIL count_stream got %h want %h", res_cnt, cnt0 + 8'd12);
      end
   endtask

   task automatic test_random();
      logic [9:0] exp_q[$];
      logic [9:0] held;
      logic       hold;
      int sent;
      int recv;
      sent = 0;
      recv = 0;
      hold = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
         in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         ps = 8'($urandom);
         pc = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || res !== held) begin
               errors++;
               $display("FAIL rand_hold got v=%b res=%h want v=1 res=%h", out_valid, res, held);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({2'b00, ps} + {1'b0, pc, 1'b0});
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_extra got res=%h want no output", res);
            end else begin
               if (res !== exp_q[0]) begin
                  errors++; $display("FAIL rand_res%0d got %h want %h", recv, res, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            recv++;
         end
         hold = out_valid && !out_ready;
         held = res;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (recv != 1000) begin
         errors++; $display("FAIL rand_total got %0d want 1000", recv);
      end
   endtask

   initial begin
      test_reset();
      test_single("ps55_pcaa", 8'h55, 8'hAA, 10'h1A9);
      test_single("psff_pcff", 8'hFF, 8'hFF, 10'h2FD);
      test_single("ps00_pc00", 8'h00, 8'h00, 10'h000);
      test_single("ps0f_pc08", 8'h0F, 8'h08, 10'h01F);
      test_back_to_back();
      test_reset_inflight();
      test_count_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
